// File: rtl/exec_pkg.sv
// exec_pkg: shared types and helpers for the EX pipeline stage.
//   alu_op_t       - 4-bit ALU operation code (13-15 reserved)
//   exec_state_t   - EX stage sequencing states
//   DIV0_QUOTIENT  - quotient returned for an unsigned divide by zero
//   is_multicycle  - true for ops that go through the iterative mul/div unit
// Optional build macro: MUL_SINGLE_CYCLE_EN (MUL becomes a 1-cycle op).
package exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_MUL   = 4'd8,
    OP_DIVU  = 4'd9,
    OP_REMU  = 4'd10,
    OP_PASSB = 4'd11,
    OP_SLT   = 4'd12
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } exec_state_t;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  // Ops that need the iterative unit (divide by zero is filtered separately).
  function automatic logic is_multicycle(input alu_op_t op);
    logic r;
    case (op)
`ifdef MUL_SINGLE_CYCLE_EN
      OP_MUL:           r = 1'b0;
`else
      OP_MUL:           r = 1'b1;
`endif
      OP_DIVU, OP_REMU: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/execute_stage_seq_muldiv.sv
// seq_muldiv: iterative DATA_WIDTH-step unsigned multiplier / restoring divider.
//   clk, rst_n     - clock, async active-low reset
//   start          - load operands and begin (op_a, op_b, is_div, is_rem)
//   abort          - drop the operation in progress (wins over start)
//   done           - high in the cycle whose edge completes the last step
//   result         - final value, valid while done is high (includes last step)
module seq_muldiv
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  is_div,
  input  logic                  is_rem,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  // acc_r: product (MUL) or partial remainder (DIV)
  // shreg_r: multiplier shifting right (MUL) or dividend/quotient shifting left (DIV)
  // opb_r: multiplicand shifting left (MUL) or divisor (DIV)
  logic [DATA_WIDTH-1:0] acc_r;
  logic [DATA_WIDTH-1:0] shreg_r;
  logic [DATA_WIDTH-1:0] opb_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  busy_r;
  logic                  div_r;
  logic                  rem_r;

  logic [DATA_WIDTH:0]   rem_shift_s;
  logic [DATA_WIDTH:0]   diff_s;
  logic [DATA_WIDTH-1:0] acc_nxt_s;
  logic [DATA_WIDTH-1:0] shreg_nxt_s;
  logic [DATA_WIDTH-1:0] opb_nxt_s;

  // One shift-add or restoring-divide step computed from the current registers.
  always_comb begin
    rem_shift_s = {acc_r, shreg_r[DATA_WIDTH-1]};
    diff_s      = rem_shift_s - {1'b0, opb_r};
    if (div_r) begin
      // remainder < divisor keeps the difference below 2^DATA_WIDTH; bit MSB is the borrow
      if (!diff_s[DATA_WIDTH]) begin
        acc_nxt_s   = diff_s[DATA_WIDTH-1:0];
        shreg_nxt_s = {shreg_r[DATA_WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt_s   = rem_shift_s[DATA_WIDTH-1:0];
        shreg_nxt_s = {shreg_r[DATA_WIDTH-2:0], 1'b0};
      end
      opb_nxt_s = opb_r;
    end else begin
      if (shreg_r[0]) begin
        acc_nxt_s = acc_r + opb_r;
      end else begin
        acc_nxt_s = acc_r;
      end
      shreg_nxt_s = {1'b0, shreg_r[DATA_WIDTH-1:1]};
      opb_nxt_s   = {opb_r[DATA_WIDTH-2:0], 1'b0};
    end
  end

  assign done   = busy_r && (cnt_r == CNT_W'(DATA_WIDTH - 1));
  assign result = (div_r && !rem_r) ? shreg_nxt_s : acc_nxt_s;

  // Operand load, per-step update and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= '0;
      shreg_r <= '0;
      opb_r   <= '0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      div_r   <= 1'b0;
      rem_r   <= 1'b0;
    end else if (abort) begin
      busy_r <= 1'b0;
      cnt_r  <= '0;
    end else if (start) begin
      busy_r <= 1'b1;
      cnt_r  <= '0;
      div_r  <= is_div;
      rem_r  <= is_rem;
      acc_r  <= '0;
      if (is_div) begin
        shreg_r <= op_a;
        opb_r   <= op_b;
      end else begin
        shreg_r <= op_b;
        opb_r   <= op_a;
      end
    end else if (busy_r) begin
      acc_r   <= acc_nxt_s;
      shreg_r <= shreg_nxt_s;
      opb_r   <= opb_nxt_s;
      if (done) begin
        busy_r <= 1'b0;
        cnt_r  <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: EX pipeline stage with ALU, iterative mul/div and EX/MEM registers.
//   Inputs : clk, rst_n (async active-low), flush (sync), in_valid, alu_op,
//            src_a, src_b, store_data, rd_in, reg_write_in, mem_to_reg_in, mem_write_in
//   Outputs: stall (from registered state), out_valid, alu_result, write_data_a,
//            mem_write_en, mem_to_reg, rd_out, reg_write_out (all registered)
// Optional build macro: MUL_SINGLE_CYCLE_EN - combinational MUL, never stalls.
module execute_stage
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  input  logic                  mem_write_in,
  output logic                  stall,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] write_data_a,
  output logic                  mem_write_en,
  output logic                  mem_to_reg,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  reg_write_out
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  exec_state_t           state_r;
  alu_op_t               op_s;
  logic [SHAMT_W-1:0]    shamt_s;
  logic [DATA_WIDTH-1:0] alu_s;
  logic                  is_div_s;
  logic                  start_run_s;
  logic                  md_done_s;
  logic [DATA_WIDTH-1:0] md_result_s;

  // Control captured at accept so the multi-cycle result carries its own sideband.
  logic [DATA_WIDTH-1:0] store_data_r;
  logic [REG_ADDR_W-1:0] rd_r;
  logic                  reg_write_r;
  logic                  mem_to_reg_r;
  logic                  mem_write_r;

  assign op_s     = alu_op_t'(alu_op);
  assign shamt_s  = src_b[SHAMT_W-1:0];
  assign is_div_s = (op_s == OP_DIVU) || (op_s == OP_REMU);
  // Divide by zero resolves in one cycle instead of entering a RUN state.
  assign start_run_s = in_valid && is_multicycle(op_s) && !(is_div_s && (src_b == '0));
  assign stall       = (state_r != IDLE);

  // Single-cycle ALU result, including the divide-by-zero answers.
  always_comb begin
    alu_s = '0;
    case (op_s)
      OP_ADD:   alu_s = src_a + src_b;
      OP_SUB:   alu_s = src_a - src_b;
      OP_AND:   alu_s = src_a & src_b;
      OP_OR:    alu_s = src_a | src_b;
      OP_XOR:   alu_s = src_a ^ src_b;
      OP_SLL:   alu_s = src_a << shamt_s;
      OP_SRL:   alu_s = src_a >> shamt_s;
      OP_SRA:   alu_s = $signed(src_a) >>> shamt_s;
`ifdef MUL_SINGLE_CYCLE_EN
      OP_MUL:   alu_s = src_a * src_b;
`else
      OP_MUL:   alu_s = '0;
`endif
      OP_DIVU:  alu_s = DATA_WIDTH'(DIV0_QUOTIENT);
      OP_REMU:  alu_s = src_a;
      OP_PASSB: alu_s = src_b;
      OP_SLT:   alu_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default:  alu_s = '0;
    endcase
  end

  seq_muldiv #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start ((state_r == IDLE) && start_run_s),
    .abort (flush),
    .is_div(is_div_s),
    .is_rem(op_s == OP_REMU),
    .op_a  (src_a),
    .op_b  (src_b),
    .done  (md_done_s),
    .result(md_result_s)
  );

  // Sequencing FSM and EX/MEM pipeline registers; bubbles hold data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      out_valid     <= 1'b0;
      alu_result    <= '0;
      write_data_a  <= '0;
      mem_write_en  <= 1'b0;
      mem_to_reg    <= 1'b0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      store_data_r  <= '0;
      rd_r          <= '0;
      reg_write_r   <= 1'b0;
      mem_to_reg_r  <= 1'b0;
      mem_write_r   <= 1'b0;
    end else if (flush) begin
      state_r       <= IDLE;
      out_valid     <= 1'b0;
      mem_write_en  <= 1'b0;
      reg_write_out <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_run_s) begin
            state_r       <= is_div_s ? DIV_RUN : MUL_RUN;
            store_data_r  <= store_data;
            rd_r          <= rd_in;
            reg_write_r   <= reg_write_in;
            mem_to_reg_r  <= mem_to_reg_in;
            mem_write_r   <= mem_write_in;
            out_valid     <= 1'b0;
            mem_write_en  <= 1'b0;
            reg_write_out <= 1'b0;
          end else if (in_valid) begin
            out_valid     <= 1'b1;
            alu_result    <= alu_s;
            write_data_a  <= store_data;
            mem_write_en  <= mem_write_in;
            mem_to_reg    <= mem_to_reg_in;
            rd_out        <= rd_in;
            reg_write_out <= reg_write_in;
          end else begin
            out_valid     <= 1'b0;
            mem_write_en  <= 1'b0;
            reg_write_out <= 1'b0;
          end
        end
        MUL_RUN, DIV_RUN: begin
          if (md_done_s) begin
            state_r       <= IDLE;
            out_valid     <= 1'b1;
            alu_result    <= md_result_s;
            write_data_a  <= store_data_r;
            mem_write_en  <= mem_write_r;
            mem_to_reg    <= mem_to_reg_r;
            rd_out        <= rd_r;
            reg_write_out <= reg_write_r;
          end else begin
            out_valid     <= 1'b0;
            mem_write_en  <= 1'b0;
            reg_write_out <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          out_valid     <= 1'b0;
          mem_write_en  <= 1'b0;
          reg_write_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the pipelined core, directly upstream of memory_stage.
- Computes ALU result; iterative multiply/divide stalls upstream while running.
- Registers the EX/MEM pipeline boundary: alu_result (memory address or writeback value), write_data_a (store data), mem_write_en, mem_to_reg, plus destination-register sideband.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match memory_stage port A.
- REG_ADDR_W, 4, destination register index width.

Ports:
- clk  in  1  stage clock (memory_stage clk_a domain).
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  instruction present on inputs.
- alu_op  in  4  operation code (exec_pkg::alu_op_t).
- src_a  in  DATA_WIDTH  operand A.
- src_b  in  DATA_WIDTH  operand B (register or immediate, already muxed).
- store_data  in  DATA_WIDTH  rs2 value for stores.
- rd_in  in  REG_ADDR_W  destination register.
- reg_write_in  in  1  writeback enable.
- mem_to_reg_in  in  1  load select.
- mem_write_in  in  1  store enable.
- stall  out  1  upstream must hold its current instruction.
- out_valid  out  1  EX/MEM slot holds a real instruction.
- alu_result  out  DATA_WIDTH  ALU/mul/div result.
- write_data_a  out  DATA_WIDTH  registered store_data.
- mem_write_en  out  1  registered mem_write_in, gated by out_valid.
- mem_to_reg  out  1  registered mem_to_reg_in.
- rd_out  out  REG_ADDR_W  registered rd_in.
- reg_write_out  out  1  registered reg_write_in, gated by out_valid.

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; stall 0.
- Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA (shift amount = src_b[4:0]), 8 MUL (low 32 bits), 9 DIVU, 10 REMU, 11 PASSB, 12 SLT (signed, result 0/1). Codes 13-15 reserved: result 0, control passed through.
- Arithmetic wraps modulo 2^DATA_WIDTH; no overflow flag.
- Single-cycle ops: inputs sampled on edge E; outputs valid after E (latency 1).
- in_valid=0 in IDLE: bubble (out_valid, mem_write_en, reg_write_out = 0; data outputs hold last value).
- FSM states IDLE, MUL_RUN, DIV_RUN.
  - IDLE + in_valid + op 8/9/10: latch operands, control and op; counter = 0; go to RUN.
  - Each RUN cycle performs one shift-add (MUL) or restoring-divide (DIV) step; counter increments.
  - At counter = DATA_WIDTH-1: result written to outputs with out_valid=1 on that edge; return to IDLE.
- Multi-cycle latency: accepted at edge E0, result on outputs after E0+DATA_WIDTH (32).
- stall = (state != IDLE), driven from registered state.
  - Upstream advances on the accept edge and holds the next instruction while stall=1.
  - Inputs are ignored during RUN; EX/MEM emits bubbles for the whole stall.
- DIVU/REMU by zero: detected at accept; no RUN entered; 1-cycle result (quotient 0xFFFFFFFF, remainder = src_a).
- flush (synchronous): state to IDLE, next outputs are a bubble, counter cleared.
  - Beats in_valid in the same cycle; that instruction is dropped.
  - Aborts an in-progress RUN; its result is never emitted.
- rst_n asserted mid-RUN: immediate return to reset values.

Optional Feature:
- MUL_SINGLE_CYCLE_EN defined: MUL uses a combinational multiply, latency 1, never raises stall; DIV/REM unchanged.
- Not defined: MUL is iterative as described above.

Decomposition:
- exec_pkg:
  - alu_op_t enum (4-bit, codes above).
  - exec_state_t enum {IDLE, MUL_RUN, DIV_RUN}.
  - is_multicycle() function.
  - DIV0_QUOTIENT constant.
- Sub-module seq_muldiv:
  - Iterative 32-step multiplier/restoring divider with start/abort/done.
  - execute_stage holds the FSM, ALU case statement and EX/MEM registers.

Test Plan:
- Reset: hold rst_n low with in_valid=1 -> all outputs 0, stall 0; release -> first ADD 7+5 gives alu_result=12, out_valid=1 one edge later.
- Store: op ADD, src_a=1, src_b=2, store_data=0x55555551, mem_write_in=1 -> next edge alu_result=3, write_data_a=0x55555551, mem_write_en=1; in_valid=0 the following cycle -> mem_write_en=0.
- MUL: 0x0001_0003 x 0x0000_0005 -> stall high for exactly 32 cycles with bubbles on outputs; then alu_result=0x0005_000F, out_valid=1 for one cycle.
- DIVU/REMU: 100/7 -> alu_result=14 after 32 cycles; REMU -> 2; DIVU 9/0 -> 0xFFFFFFFF after 1 cycle with stall never asserted.
- Flush mid-DIV (cycle 10 of RUN) -> stall drops next edge, no valid output from the aborted op; flush together with in_valid ADD -> ADD dropped.
- Signed edges: SRA 0x8000_0000 by 31 -> 0xFFFFFFFF; SLT -1 < 1 -> 1; SUB 0-1 -> 0xFFFFFFFF.
